// File: rtl/lfsr_pkg.sv
// Shared constants for the LFSR tap search controller.
// Holds the candidate tap table, the preamble character and the FSM states.
package lfsr_pkg;

    localparam int NUM_TAPS = 9;

    localparam logic [6:0] PREAMBLE_CHAR = 7'h20;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD_TAP,
        S_LOAD_SEED,
        S_CHECK,
        S_DONE
    } state_t;

    // Candidate tap patterns, tried in ascending index order.
    function automatic logic [6:0] tap_of(input logic [3:0] idx);
        logic [6:0] tap;
        tap = 7'h00;
        unique case (idx)
            4'd0:    tap = 7'h60;
            4'd1:    tap = 7'h48;
            4'd2:    tap = 7'h78;
            4'd3:    tap = 7'h72;
            4'd4:    tap = 7'h6A;
            4'd5:    tap = 7'h69;
            4'd6:    tap = 7'h5C;
            4'd7:    tap = 7'h7E;
            4'd8:    tap = 7'h7B;
            default: tap = 7'h00;
        endcase
        return tap;
    endfunction

endpackage

// File: rtl/lfsr_tap_search.sv
// Finds which candidate tap pattern produced the keystream of a message
// whose preamble is all spaces, by driving an external 7-bit LFSR.
// Ports: Clk/Reset_n (async, active low); start; mem_addr/mem_data
// (read port, data one cycle after address); lfsr_init/lfsr_set/lfsr_adv/
// lfsr_in/lfsr_state (LFSR control); busy, done, found, tap_idx, tap_out.
module lfsr_tap_search
    import lfsr_pkg::*;
#(
    parameter int         PRE_LEN  = 8,
    parameter logic [7:0] MSG_BASE = 8'd0
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       start,
    output logic [7:0] mem_addr,
    input  logic [7:0] mem_data,
    output logic       lfsr_init,
    output logic       lfsr_set,
    output logic       lfsr_adv,
    output logic [6:0] lfsr_in,
    input  logic [6:0] lfsr_state,
    output logic       busy,
    output logic       done,
    output logic       found,
    output logic [3:0] tap_idx,
    output logic [6:0] tap_out
);

    localparam logic [4:0] LAST_K = 5'(PRE_LEN);
    localparam logic [3:0] LAST_C = 4'(PRE_LEN - 1);
    localparam logic [3:0] LAST_T = 4'(NUM_TAPS - 1);

    state_t     r_state;
    state_t     w_next;
    logic [4:0] r_k;
    logic [3:0] r_c;
    logic [3:0] r_t;
    logic [6:0] r_buf [0:15];
    logic       r_found;
    logic [3:0] r_tap_idx;
    logic [6:0] r_tap_out;

    logic       w_match;
    logic       w_last_c;
    logic [4:0] w_cap_k;
    logic [3:0] w_cap_idx;
    logic       w_unused;

    // Bit 7 of the ciphertext does not take part in the 7-bit keystream.
    assign w_unused  = mem_data[7];

    assign w_match   = (lfsr_state == r_buf[r_c]);
    assign w_last_c  = (r_c == LAST_C);
    // Fetch cycle k captures the byte addressed in cycle k-1.
    assign w_cap_k   = r_k - 5'd1;
    assign w_cap_idx = w_cap_k[3:0];

    assign found     = r_found;
    assign tap_idx   = r_tap_idx;
    assign tap_out   = r_tap_out;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_k       <= '0;
            r_c       <= '0;
            r_t       <= '0;
            r_found   <= 1'b0;
            r_tap_idx <= '0;
            r_tap_out <= '0;
            for (int i = 0; i < 16; i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_found   <= 1'b0;
                        r_tap_idx <= '0;
                        r_tap_out <= '0;
                        r_k       <= '0;
                    end
                end
                S_FETCH: begin
                    if (r_k != 5'd0) begin
                        r_buf[w_cap_idx] <= mem_data[6:0] ^ PREAMBLE_CHAR;
                    end
                    r_k <= r_k + 5'd1;
                    if (r_k == LAST_K) begin
                        r_t <= '0;
                    end
                end
                S_LOAD_TAP: begin
                end
                S_LOAD_SEED: begin
                    r_c <= '0;
                end
                S_CHECK: begin
                    if (w_match) begin
                        if (w_last_c) begin
                            r_found   <= 1'b1;
                            r_tap_idx <= r_t;
                            r_tap_out <= tap_of(r_t);
                        end else begin
                            r_c <= r_c + 4'd1;
                        end
                    end else if (r_t != LAST_T) begin
                        r_t <= r_t + 4'd1;
                    end
                end
                S_DONE: begin
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        w_next    = r_state;
        mem_addr  = 8'h00;
        lfsr_init = 1'b0;
        lfsr_set  = 1'b0;
        lfsr_adv  = 1'b0;
        lfsr_in   = 7'h00;
        busy      = 1'b1;
        done      = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_next = S_FETCH;
                end
            end
            S_FETCH: begin
                // Address arithmetic wraps naturally at 8 bits.
                mem_addr = MSG_BASE + {3'b000, r_k};
                if (r_k == LAST_K) begin
                    w_next = S_LOAD_TAP;
                end
            end
            S_LOAD_TAP: begin
                lfsr_init = 1'b1;
                lfsr_in   = tap_of(r_t);
                w_next    = S_LOAD_SEED;
            end
            S_LOAD_SEED: begin
                lfsr_set = 1'b1;
                lfsr_in  = r_buf[0];
                w_next   = S_CHECK;
            end
            S_CHECK: begin
                lfsr_adv = 1'b1;
                if (w_match) begin
                    if (w_last_c) begin
                        w_next = S_DONE;
                    end
                end else if (r_t == LAST_T) begin
                    w_next = S_DONE;
                end else begin
                    w_next = S_LOAD_TAP;
                end
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_lfsr_tap_search.sv
// Scoreboard bench for lfsr_tap_search with a behavioural LFSR and memory.
// Expected results come from a tap-by-tap keystream search model.
module tb_lfsr_tap_search;

    localparam int         P    = 8;
    localparam logic [7:0] BASE = 8'hFC;
    localparam logic [6:0] TB_TAPS [9] = '{
        7'h60, 7'h48, 7'h78, 7'h72, 7'h6A, 7'h69, 7'h5C, 7'h7E, 7'h7B
    };

    typedef struct {
        bit         f;
        int         idx;
        logic [6:0] tap;
        int         lat;
        int         s;
    } exp_t;

    logic       Clk;
    logic       Reset_n;
    logic       start;
    logic [7:0] mem_addr;
    logic [7:0] mem_data;
    logic       lfsr_init;
    logic       lfsr_set;
    logic       lfsr_adv;
    logic [6:0] lfsr_in;
    logic [6:0] lfsr_state;
    logic       busy;
    logic       done;
    logic       found;
    logic [3:0] tap_idx;
    logic [6:0] tap_out;

    logic [7:0] mem [256];
    logic [6:0] env_tap;
    int         cyc;
    int         n_cmp;
    int         n_bad;
    exp_t       sbq [$];

    lfsr_tap_search #(
        .PRE_LEN  (P),
        .MSG_BASE (BASE)
    ) dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .start      (start),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data),
        .lfsr_init  (lfsr_init),
        .lfsr_set   (lfsr_set),
        .lfsr_adv   (lfsr_adv),
        .lfsr_in    (lfsr_in),
        .lfsr_state (lfsr_state),
        .busy       (busy),
        .done       (done),
        .found      (found),
        .tap_idx    (tap_idx),
        .tap_out    (tap_out)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    // Shift left, feed back the parity of the tapped bits.
    function automatic logic [6:0] step(input logic [6:0] s,
                                        input logic [6:0] tp);
        int fb;
        fb = $countones(s & tp) % 2;
        return 7'((int'(s) * 2 + fb) % 128);
    endfunction

    always @(posedge Clk) mem_data <= mem[mem_addr];

    always @(posedge Clk) begin
        if (lfsr_init) env_tap <= lfsr_in;
        else if (lfsr_set) lfsr_state <= lfsr_in;
        else if (lfsr_adv) lfsr_state <= step(lfsr_state, env_tap);
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge Clk) begin
        if (lfsr_init || lfsr_set) begin
            chk("init_set_excl", int'(lfsr_init && lfsr_set), 0);
        end
    end

    always @(negedge Clk) begin
        exp_t e;
        if (Reset_n && done) begin
            if (sbq.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                e = sbq.pop_front();
                chk("found", int'(found), int'(e.f));
                chk("tap_idx", int'(tap_idx), e.idx);
                chk("tap_out", int'(tap_out), int'(e.tap));
                chk("latency", cyc - e.s, e.lat);
            end
        end
    end

    task automatic model(output exp_t e);
        logic [6:0] ks [P];
        logic [6:0] s;
        int         n;
        bit         ok;
        for (int c = 0; c < P; c++) begin
            ks[c] = mem[8'((int'(BASE) + c) % 256)][6:0] ^ 7'h20;
        end
        e.f   = 1'b0;
        e.idx = 0;
        e.tap = 7'h00;
        e.s   = 0;
        e.lat = 1 + (P + 1);
        for (int t = 0; t < 9; t++) begin
            s  = ks[0];
            n  = 0;
            ok = 1'b1;
            for (int c = 0; c < P; c++) begin
                n++;
                if (s != ks[c]) begin
                    ok = 1'b0;
                    break;
                end
                s = step(s, TB_TAPS[t]);
            end
            e.lat += 2 + n;
            if (ok) begin
                e.f   = 1'b1;
                e.idx = t;
                e.tap = TB_TAPS[t];
                break;
            end
        end
    endtask

    task automatic fill_rand();
        for (int a = 0; a < 256; a++) mem[a] = 8'($urandom);
    endtask

    task automatic plant(input logic [6:0] seed, input int t);
        logic [6:0] s;
        s = seed;
        for (int c = 0; c < P; c++) begin
            mem[8'((int'(BASE) + c) % 256)] = {1'($urandom), s ^ 7'h20};
            s = step(s, TB_TAPS[t]);
        end
    endtask

    task automatic do_search(input bit poke);
        exp_t e;
        int   w;
        model(e);
        @(negedge Clk);
        start = 1'b1;
        e.s   = cyc;
        sbq.push_back(e);
        @(negedge Clk);
        start = 1'b0;
        chk("busy_after_start", int'(busy), 1);
        for (int i = 0; i < P; i++) begin
            chk("mem_addr", int'(mem_addr), (int'(BASE) + i) % 256);
            @(negedge Clk);
        end
        if (poke) begin
            start = 1'b1;
            @(negedge Clk);
            start = 1'b0;
        end
        w = 0;
        while (sbq.size() != 0 && w < 400) begin
            @(negedge Clk);
            w++;
        end
        if (sbq.size() != 0) begin
            chk("done_timeout", 0, 1);
            sbq.delete();
        end
        @(negedge Clk);
        chk("idle_after_done", int'(busy), 0);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_found"}, int'(found), 0);
        chk({tag, "_tap_idx"}, int'(tap_idx), 0);
        chk({tag, "_tap_out"}, int'(tap_out), 0);
        chk({tag, "_mem_addr"}, int'(mem_addr), 0);
        chk({tag, "_strobes"}, int'({lfsr_init, lfsr_set, lfsr_adv}), 0);
        chk({tag, "_lfsr_in"}, int'(lfsr_in), 0);
    endtask

    initial begin
        logic [7:0] pre [P];
        int         w;
        n_cmp   = 0;
        n_bad   = 0;
        Reset_n = 1'b0;
        start   = 1'b0;
        pre     = '{8'h21, 8'h22, 8'h24, 8'h28, 8'h30, 8'h00, 8'h61, 8'h23};
        fill_rand();
        repeat (3) @(negedge Clk);
        chk_reset_outs("rst");
        Reset_n = 1'b1;

        for (int c = 0; c < P; c++) begin
            mem[8'((int'(BASE) + c) % 256)] = pre[c];
        end
        do_search(1'b0);

        fill_rand();
        plant(7'h55, 8);
        do_search(1'b1);

        for (int c = 0; c < P; c++) begin
            mem[8'((int'(BASE) + c) % 256)] = 8'hFF;
        end
        do_search(1'b0);

        for (int i = 0; i < 12; i++) begin
            fill_rand();
            if (i % 2 == 0) begin
                plant(7'($urandom_range(1, 127)), int'($urandom_range(0, 8)));
            end
            do_search(1'b0);
        end

        fill_rand();
        plant(7'h55, 8);
        @(negedge Clk);
        start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        w = 0;
        while (!lfsr_adv && w < 200) begin
            @(negedge Clk);
            w++;
        end
        chk("reached_check", int'(lfsr_adv), 1);
        @(negedge Clk);
        Reset_n = 1'b0;
        #1;
        chk_reset_outs("abort");
        repeat (2) begin
            @(negedge Clk);
            chk("abort_no_done", int'(done), 0);
        end
        Reset_n = 1'b1;
        do_search(1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/lfsr_tap_search.md
# lfsr_tap_search

Controller that sequences the 7-bit LFSR to identify which of the fixed tap patterns generated an encrypted message. It reads the message preamble from data memory once and derives the expected keystream, assuming every preamble character is a space (0x20). It then cycles each candidate tap pattern through the LFSR's init/set/advance controls and compares the LFSR state against that keystream. It sits between the data-memory read port and the LFSR instance, ahead of the decryption datapath, which consumes `tap_idx`/`tap_out`.

## Interface
Parameters:
- `PRE_LEN`, 8: preamble characters checked; legal range 2..16.
- `MSG_BASE`, 8'd0: data-memory address of the first ciphertext byte.

Ports:
- `Clk` input 1: clock, all state on rising edge.
- `Reset_n` input 1: asynchronous, active-low reset.
- `start` input 1: begin a search; sampled only in IDLE.
- `mem_addr` output 8: data-memory read address.
- `mem_data` input 8: read data, valid one cycle after `mem_addr`.
- `lfsr_init` output 1: LFSR tap-pattern load strobe.
- `lfsr_set` output 1: LFSR state load strobe.
- `lfsr_adv` output 1: LFSR advance strobe.
- `lfsr_in` output 7: tap pattern or seed driven to the LFSR.
- `lfsr_state` input 7: current LFSR state.
- `busy` output 1: high in every state except IDLE.
- `done` output 1: one-cycle pulse at the end of a search.
- `found` output 1: a matching tap was found; held until the next `start`.
- `tap_idx` output 4: index of the matching tap; 0 if none matched.
- `tap_out` output 7: matching tap pattern; 0 if none matched.

## Operation
- States: IDLE, FETCH, LOAD_TAP, LOAD_SEED, CHECK, DONE.
- Keystream register `buf[c] = mem_data[6:0] ^ 7'h20`, for c = 0..PRE_LEN-1.
- IDLE: all strobes 0, `mem_addr`=0. On `start`=1, clear `found`, `tap_idx` and `tap_out`, and go to FETCH. `start` in any other state is ignored.
- FETCH:
  - Issue addresses MSG_BASE..MSG_BASE+PRE_LEN-1 on consecutive cycles.
  - Capture each returned byte into `buf` on the following cycle; address arithmetic wraps mod 256.
  - After the last capture, set t=0 and go to LOAD_TAP.
- LOAD_TAP: `lfsr_init`=1, `lfsr_in`=TAPS[t]. Never assert `lfsr_init` and `lfsr_set` together, because the LFSR gives init priority.
- LOAD_SEED: `lfsr_set`=1, `lfsr_in`=buf[0]. Set c=0.
- CHECK, one cycle per character:
  - Compare `lfsr_state` with buf[c], with `lfsr_adv`=1.
  - Match and c==PRE_LEN-1: latch `found`=1, `tap_idx`=t, `tap_out`=TAPS[t]; go to DONE.
  - Match otherwise: c++.
  - Mismatch and t<NUM_TAPS-1: t++, go to LOAD_TAP.
  - Mismatch and t==NUM_TAPS-1: go to DONE with `found`=0.
- The advance strobe on the final CHECK cycle is harmless: the LFSR is always reloaded before reuse.
- DONE: `done`=1 for one cycle, then IDLE.
- Taps are tried in ascending index order; the first match wins.
- The LFSR has no reset. Every search performs init then set before any compare, so no LFSR state is trusted across searches.

## Timing
- Reset values: state=IDLE; `busy`, `done`, `found`, all strobes, `mem_addr`, `lfsr_in`, `tap_idx` and `tap_out` all 0.
- `start` high in cycle 0 puts the FSM in FETCH in cycle 1. FETCH lasts PRE_LEN+1 cycles.
- Each candidate tap costs 2 cycles plus the number of CHECK cycles up to and including the first mismatch.
- A match on tap t completes in 1 + (PRE_LEN+1) + 2(t+1) + Σ(check cycles of taps 0..t) cycles, followed by the DONE cycle.
- The `done` pulse and the final `found`/`tap_idx`/`tap_out` values appear in the same cycle.
- All outputs are registered or decoded from state only; there is no combinational path from `mem_data` or `lfsr_state` to any output.
- `Reset_n` low in any state forces IDLE and the reset values immediately, with no `done` pulse. A partially filled `buf` is discarded.

## Structure
- Package `lfsr_pkg` holds:
  - `NUM_TAPS`=9.
  - `TAPS[0:8]` = 7'h60, 7'h48, 7'h78, 7'h72, 7'h6A, 7'h69, 7'h5C, 7'h7E, 7'h7B.
  - The `PREAMBLE_CHAR`=7'h20 constant.
  - The state enum.
- No sub-module inside the block. The LFSR is instantiated alongside it at the top level and wired to the `lfsr_*` ports.

## Test plan
- Reset: `Reset_n`=0 → all outputs 0, `busy`=0; `start` pulse after release → `busy`=1 next cycle.
- Tap 0 match, PRE_LEN=8, seed 7'h01:
  - Memory holds 21,22,24,28,30,00,61,23 (keystream 01,02,04,08,10,20,41,03).
  - Expected: `done`, `found`=1, `tap_idx`=0, `tap_out`=7'h60, with no earlier CHECK mismatch.
- Tap 8 match (7'h7B), seed 7'h55, preamble generated by a bench model → `found`=1, `tap_idx`=8 after taps 0..7 each mismatch and reload.
- No match: memory all 8'hFF → `done` pulse with `found`=0, `tap_idx`=0, `tap_out`=0.
- Control checks:
  - `lfsr_init` and `lfsr_set` are never high together.
  - A `start` pulse while `busy` is ignored.
  - `mem_addr` wraps from 8'hFF to 8'h00 when MSG_BASE=8'hFC.
- `Reset_n` asserted mid-CHECK → IDLE immediately with no `done`; a following `start` yields the correct result.
